// File: rtl/alu_shift_pkg.sv
// Shared definitions for the shift sequencer: direction encodings and FSM states.
package alu_shift_pkg;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/shift_seq_if.sv
// Request/result bundle for shift_seq. SHIFT_SEQ_ARITH_EN adds the arith request bit.
interface shift_seq_if #(
   parameter int N  = 4,
   parameter int SW = $clog2(N) + 1
);

   // Valid/ready: a transfer happens on a posedge where valid && ready are both high;
   // the producer holds its payload stable while valid && !ready.
   logic          in_valid;
   logic          in_ready;
   logic          dir;
   logic [N-1:0]  a;
   logic [SW-1:0] amt;
`ifdef SHIFT_SEQ_ARITH_EN
   logic          arith;
`endif
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  y;

`ifdef SHIFT_SEQ_ARITH_EN
   modport master (output in_valid, dir, a, amt, arith, out_ready,
                   input  in_ready, out_valid, y);
   modport slave  (input  in_valid, dir, a, amt, arith, out_ready,
                   output in_ready, out_valid, y);
`else
   modport master (output in_valid, dir, a, amt, out_ready,
                   input  in_ready, out_valid, y);
   modport slave  (input  in_valid, dir, a, amt, out_ready,
                   output in_ready, out_valid, y);
`endif

endinterface

// File: rtl/shift_step.sv
// Single-step shifter datapath: one bit right (fill enters at MSB) or left (zero enters at LSB).
module shift_step
   import alu_shift_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         dir,
   input  logic         fill,
   input  logic [N-1:0] d,
   output logic [N-1:0] y
);

   always_comb begin
      if (dir == DIR_RIGHT) begin
         y = {fill, d[N-1:1]};
      end else begin
         y = {d[N-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/shift_seq.sv
// Serial shift sequencer: accepts an operand, shifts one bit per clock, presents the result.
// Build with SHIFT_SEQ_ARITH_EN for sign-filling right shifts (extra arith request bit).
module shift_seq
   import alu_shift_pkg::*;
#(
   parameter int N  = 4,
   parameter int SW = $clog2(N) + 1
) (
   input  logic        clk,
   input  logic        rst,
   shift_seq_if.slave  bus,
   output logic        busy,
   output state_t      dbg_state
);

   state_t        state;
   state_t        state_n;
   logic [N-1:0]  data;
   logic [N-1:0]  step_y;
   logic [SW-1:0] cnt;
   logic [SW-1:0] amt_sat;
   logic          dir_r;
   logic          fill_r;
   logic          fill_in;
   logic          load;
   logic          step_en;
   logic          in_ready;
   logic          out_valid;

   // Distances of N or more all produce the fully shifted-out value, so cap at N.
   assign amt_sat = (bus.amt >= SW'(N)) ? SW'(N) : bus.amt;

`ifdef SHIFT_SEQ_ARITH_EN
   // Latching the original sign once keeps every step filling with the same bit.
   assign fill_in = bus.arith & (bus.dir == DIR_RIGHT) & bus.a[N-1];
`else
   assign fill_in = 1'b0;
`endif

   shift_step #(.N(N)) u_step (
      .dir  (dir_r),
      .fill (fill_r),
      .d    (data),
      .y    (step_y)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         data   <= '0;
         cnt    <= '0;
         dir_r  <= DIR_LEFT;
         fill_r <= 1'b0;
      end else begin
         state <= state_n;
         if (load) begin
            data   <= bus.a;
            dir_r  <= bus.dir;
            fill_r <= fill_in;
            cnt    <= amt_sat;
         end else if (step_en) begin
            data <= step_y;
            cnt  <= cnt - SW'(1);
         end
      end
   end

   always_comb begin
      state_n   = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      load      = 1'b0;
      step_en   = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (bus.in_valid) begin
               load    = 1'b1;
               state_n = (amt_sat == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            step_en = 1'b1;
            if (cnt == SW'(1)) begin
               state_n = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (bus.out_ready) begin
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.y         = data;
   assign busy          = (state != IDLE);
   assign dbg_state     = state;

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq (N=8): directed table, backpressure/reset sequences,
// and a randomized sweep against a plain-arithmetic shift model.
module tb_shift_seq;
   import alu_shift_pkg::*;

   localparam int N  = 8;
   localparam int SW = 4;
`ifdef SHIFT_SEQ_ARITH_EN
   localparam bit ARITH_BUILD = 1'b1;
`else
   localparam bit ARITH_BUILD = 1'b0;
`endif

   logic   clk = 1'b0;
   logic   rst;
   logic   busy;
   state_t dbg_state;

   shift_seq_if #(.N(N), .SW(SW)) bus ();

   shift_seq #(.N(N), .SW(SW)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int              n_checks = 0;
   int              n_pass   = 0;
   logic [N-1:0]    exp_q[$];
   int              exp_cyc_q[$];

   typedef struct packed {
      logic [N-1:0]  a;
      logic          dir;
      logic [SW-1:0] amt;
      logic          arith;
      logic [N-1:0]  y;
      logic [4:0]    cyc;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference: shift by the saturated distance in one go.
   function automatic logic [N-1:0] ref_shift(input logic [N-1:0] a, input logic dir,
                                              input logic [SW-1:0] amt, input logic arith);
      int k;
      k = (amt >= N) ? N : int'(amt);
      if (dir == 1'b0) return a << k;
      if (arith && ARITH_BUILD) return $signed(a) >>> k;
      return a >> k;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive_req(input logic [N-1:0] a, input logic dir,
                            input logic [SW-1:0] amt, input logic arith);
      bus.in_valid = 1'b1;
      bus.a        = a;
      bus.dir      = dir;
      bus.amt      = amt;
`ifdef SHIFT_SEQ_ARITH_EN
      bus.arith    = arith;
`endif
   endtask

   task automatic start_op(input logic [N-1:0] a, input logic dir,
                           input logic [SW-1:0] amt, input logic arith);
      int guard = 0;
      while (!bus.in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("in_ready_before_accept", bus.in_ready, 1);
      drive_req(a, dir, amt, arith);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.a        = N'($urandom);
      bus.dir      = 1'($urandom);
      bus.amt      = SW'($urandom);
      check("busy_after_accept", busy, 1);
   endtask

   task automatic wait_result(output int cyc);
      cyc = 1;
      while (!bus.out_valid && cyc < 40) begin
         check("in_ready_while_shifting", bus.in_ready, 0);
         @(negedge clk);
         cyc++;
      end
      check("out_valid_seen", bus.out_valid, 1);
   endtask

   task automatic finish_op(input int stall, input logic poke);
      logic [N-1:0] held;
      held = bus.y;
      for (int i = 0; i < stall; i++) begin
         if (poke) begin
            bus.in_valid = 1'b1;
            bus.a        = N'($urandom);
            bus.amt      = 4'd1;
         end
         @(negedge clk);
         check("stall_out_valid", bus.out_valid, 1);
         check("stall_y_stable", bus.y, held);
         check("stall_in_ready", bus.in_ready, 0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("handshake_out_valid", bus.out_valid, 0);
      check("handshake_idle", busy, 0);
   endtask

   task automatic run_op(input logic [N-1:0] a, input logic dir, input logic [SW-1:0] amt,
                         input logic arith, input int stall, input logic poke);
      int           cyc;
      logic [N-1:0] ey;
      int           ec;
      start_op(a, dir, amt, arith);
      wait_result(cyc);
      ey = exp_q.pop_front();
      ec = exp_cyc_q.pop_front();
      check("result_y", bus.y, ey);
      check("latency", cyc, ec);
      finish_op(stall, poke);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int cyc;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.a         = '0;
      bus.dir       = 1'b0;
      bus.amt       = '0;
`ifdef SHIFT_SEQ_ARITH_EN
      bus.arith     = 1'b0;
`endif

      vecs[0] = '{8'hB3, 1'b0, 4'd3,  1'b0, 8'h98, 5'd4};
      vecs[1] = '{8'hF0, 1'b1, 4'd0,  1'b0, 8'hF0, 5'd1};
      vecs[2] = '{8'hFF, 1'b1, 4'd15, 1'b1, (ARITH_BUILD ? 8'hFF : 8'h00), 5'd9};
      vecs[3] = '{8'hFF, 1'b1, 4'd15, 1'b0, 8'h00, 5'd9};
      vecs[4] = '{8'h01, 1'b0, 4'd7,  1'b0, 8'h80, 5'd8};
      vecs[5] = '{8'h80, 1'b1, 4'd3,  1'b1, (ARITH_BUILD ? 8'hF0 : 8'h10), 5'd4};
      vecs[6] = '{8'hA5, 1'b0, 4'd8,  1'b0, 8'h00, 5'd9};
      vecs[7] = '{8'h96, 1'b1, 4'd2,  1'b1, (ARITH_BUILD ? 8'hE5 : 8'h25), 5'd3};
      vecs[8] = '{8'h6C, 1'b0, 4'd1,  1'b1, 8'hD8, 5'd2};
      vecs[9] = '{8'h7F, 1'b1, 4'd8,  1'b1, 8'h00, 5'd9};

      // Reset state
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("reset_y", bus.y, 0);
      check("reset_out_valid", bus.out_valid, 0);
      check("reset_in_ready", bus.in_ready, 1);
      check("reset_busy", busy, 0);
      check("reset_state", dbg_state, IDLE);

      // Directed table
      for (int i = 0; i < 10; i++) begin
         exp_q.push_back(vecs[i].y);
         exp_cyc_q.push_back(int'(vecs[i].cyc));
         run_op(vecs[i].a, vecs[i].dir, vecs[i].amt, vecs[i].arith, i % 3, 1'(i));
      end

      // Backpressure: stalled result stays put, a request during DONE waits for IDLE
      start_op(8'h81, 1'b1, 4'd1, 1'b0);
      wait_result(cyc);
      check("bp_latency", cyc, 2);
      check("bp_y", bus.y, 8'h40);
      for (int i = 0; i < 5; i++) begin
         drive_req(8'h03, 1'b0, 4'd1, 1'b0);
         @(negedge clk);
         check("bp_hold_valid", bus.out_valid, 1);
         check("bp_hold_y", bus.y, 8'h40);
         check("bp_not_accepted", bus.in_ready, 0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("bp_back_to_idle", busy, 0);
      check("bp_in_ready_idle", bus.in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("bp_second_accepted", busy, 1);
      wait_result(cyc);
      check("bp_second_y", bus.y, 8'h06);
      check("bp_second_latency", cyc, 2);
      finish_op(0, 1'b0);

      // Reset on the second SHIFT cycle of an amt=5 operation
      start_op(8'hAA, 1'b0, 4'd5, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("midrst_out_valid", bus.out_valid, 0);
      check("midrst_y", bus.y, 0);
      check("midrst_in_ready", bus.in_ready, 1);
      check("midrst_busy", busy, 0);
      exp_q.push_back(8'h04);
      exp_cyc_q.push_back(3);
      run_op(8'h01, 1'b0, 4'd2, 1'b0, 1, 1'b0);

      // Randomized sweep against the reference model
      for (int i = 0; i < 1000; i++) begin
         logic [N-1:0]  ra;
         logic          rd;
         logic [SW-1:0] ram;
         logic          rar;
         ra  = N'($urandom);
         rd  = 1'($urandom_range(0, 1));
         ram = SW'($urandom_range(0, 15));
         rar = 1'($urandom_range(0, 1));
         exp_q.push_back(ref_shift(ra, rd, ram, rar));
         exp_cyc_q.push_back(((ram >= N) ? N : int'(ram)) + 1);
         run_op(ra, rd, ram, rar, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/shift_seq.md
Name: shift_seq

Overview:
- Multi-bit serial shift sequencer that sits directly upstream of, and drives, the single-step shifter datapath.
- Accepts an operand, direction and shift amount via a valid/ready handshake.
- Applies one 1-bit shift per clock until the amount is exhausted, then presents the result on a valid/ready output port.
- Replaces the level-triggered load/interrupt scheme with a clean clocked FSM so the ALU can issue variable-distance shifts.

Parameters:
- N, 4, operand/result width in bits (N >= 2).
- SW, $clog2(N)+1, width of the shift-amount field; must be able to encode the value N.

Ports:
- clk  input  1  single clock; all state changes on posedge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  sequencer can accept a request.
- dir  input  1  1 = right shift, 0 = left shift; sampled on accept.
- a  input  N  operand; sampled on accept.
- amt  input  SW  shift distance; sampled on accept.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- y  output  N  result.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset: state=IDLE, data register=0, count=0, y=0, out_valid=0, busy=0, in_ready=1 in the cycle after reset. Reset overrides every other input, including mid-SHIFT and mid-DONE; any in-flight operation is discarded with no output.
- FSM states:
  - IDLE: in_ready=1.
  - SHIFT: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Accept: an edge with in_valid && in_ready && state==IDLE.
  - Loads data<=a, dir_r<=dir, cnt<=min(amt,N).
  - If the saturated count is 0, go to DONE, else go to SHIFT.
- SHIFT:
  - Each edge: data<=step(data,dir_r), cnt<=cnt-1.
  - The edge where cnt==1 performs the final step and moves to DONE.
- Latency: for effective count k, out_valid rises after the (k)th edge following the accept edge, i.e. k+1 cycles after the accept cycle; k=0 gives 1 cycle.
- Step function:
  - Right: y[i]=d[i+1], MSB filled with fill bit (0 unless the optional feature applies).
  - Left: y[i]=d[i-1], LSB=0.
- Saturation: amt >= N saturates to N, so the result is all zeros (or the sign fill, with the optional feature). Never more than N shift cycles.
- DONE:
  - y=data, held stable while out_valid && !out_ready.
  - Edge with out_ready goes to IDLE and drops out_valid.
  - No new accept in the same cycle; back-to-back throughput is one op per k+2 cycles.
- in_valid asserted during SHIFT/DONE is ignored (not accepted, not queued); inputs a/dir/amt may change freely after accept.
- dir is latched; it cannot change mid-operation.
- busy = (state != IDLE).

Optional Feature:
- Macro: SHIFT_SEQ_ARITH_EN.
- With it:
  - Extra input port arith (1 bit), sampled on accept.
  - Right shifts with arith=1 fill the MSB with the original operand MSB every step.
  - Saturated right arithmetic shift yields all copies of the sign bit.
  - Left shifts are unaffected.
- Without it: no arith port; fill is always 0.

Decomposition:
- Shared package alu_shift_pkg:
  - Direction constants DIR_LEFT=1'b0, DIR_RIGHT=1'b1.
  - FSM state enum: IDLE, SHIFT, DONE.
- One combinational sub-module shift_step(dir, fill, d -> y): the 1-bit shift datapath. Instantiated once and fed from the data register.
- The FSM, counter and handshake logic stay in shift_seq.

Test Plan:
- N=8, a=8'b1011_0011, dir=0, amt=3 -> out_valid 4 cycles after accept, y=8'b1001_1000, in_ready low until the out handshake.
- N=8, a=8'hF0, dir=1, amt=0 -> out_valid 1 cycle after accept, y=8'hF0.
- N=8, a=8'hFF, dir=1, amt=15 (saturates to 8) -> exactly 8 shift cycles, y=8'h00; with SHIFT_SEQ_ARITH_EN and arith=1 -> y=8'hFF.
- Backpressure: a=8'h81, dir=1, amt=1, out_ready held 0 for 5 cycles -> y=8'h40 stable with out_valid=1 throughout; second in_valid during the stall is not accepted; accepted only after the handshake returns to IDLE.
- rst asserted on the 2nd SHIFT cycle of an amt=5 op -> next cycle out_valid=0, y=0, in_ready=1; a following op a=8'h01, dir=0, amt=2 gives y=8'h04.
- Random a/dir/amt sweep, 1000 ops with random out_ready -> y matches the reference model (a<<amt or a>>amt, saturating); cycle count equals min(amt,N)+1.
